fifo_infill_wrapper: RTL and testbench
======================================

# fifo_infill_wrapper

Single-clock, show-ahead FIFO with an Avalon-ST style valid/ready data path and a small CSR port that exposes the current fill level. It serves as the free-pointer list of the reassembly linked-list engine: it is pre-filled with every free address after reset, popped on allocation and pushed on garbage collection. Storage is an internal inferred dual-port RAM (one write port, one read port).

## Interface
- SYMBOLS_PER_BEAT, 1: symbols per data word.
- BITS_PER_SYMBOL, 8: bits per symbol; data width W = SYMBOLS_PER_BEAT*BITS_PER_SYMBOL.
- FIFO_DEPTH, 16: number of entries; power of two, at least 2; the FIFO holds exactly FIFO_DEPTH words.

- clk  in  1  single clock; all logic rises on posedge.
- reset  in  1  asynchronous, active-low reset.
- csr_address  in  3  CSR register select.
- csr_read  in  1  CSR read strobe; may be tied high.
- csr_write  in  1  CSR write strobe; writes are ignored.
- csr_writedata  in  32  unused.
- csr_readdata  out  32  registered CSR read data.
- in_data  in  W  push data.
- in_valid  in  1  push request.
- in_ready  out  1  FIFO can accept a word.
- out_data  out  W  head-of-FIFO word, valid while out_valid.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  pop request.

## Operation
- Push occurs on a rising edge where in_valid && in_ready; pop occurs where out_valid && out_ready.
- in_ready = (fill < FIFO_DEPTH), driven from registered state only; independent of out_ready.
- Show-ahead: out_data always presents the oldest stored word with no read request; a consumer may sample out_data and assert out_ready in the same cycle.
- Order strictly first-in first-out; words are returned bit-exact.
- Write and read pointers are log2(FIFO_DEPTH) bits and wrap naturally from FIFO_DEPTH-1 to 0; fill counter is log2(FIFO_DEPTH)+1 bits.
- Simultaneous push and pop: both take effect; fill unchanged.
- Push while full: word not accepted, state unchanged.
- Pop while empty: ignored, state unchanged.
- CSR map, read-only: address 0 = fill level (zero-extended to 32 bits); address 1 = FIFO_DEPTH; all other addresses read 0. csr_write has no effect.

## Timing
- Reset (reset low, asynchronous): pointers and fill = 0, out_valid = 0, out_data = 0, csr_readdata = 0, in_ready = 1.
- Reset asserted mid-operation discards all contents immediately; no partial words survive.
- Push-to-output latency 1 cycle: a word pushed into an empty FIFO at edge N gives out_valid = 1 with that word on out_data after edge N.
- Pop takes effect at the edge; the next word (or out_valid = 0) appears after that edge.
- in_ready falls in the cycle after the push that makes fill = FIFO_DEPTH, and rises in the cycle after the first pop from full.
- csr_readdata updates 1 cycle after the edge on which csr_read is high and holds its value otherwise; with csr_read tied high it tracks fill with 1-cycle lag.

## Configuration
- FIFO_CHECK_EN defined: simulation checks are compiled in; push attempted while full (in_valid && !in_ready) or pop attempted while empty (out_ready && !out_valid) reports an error naming the condition and ends simulation.
- FIFO_CHECK_EN undefined: no checks compiled; these cases are silently ignored as described in Operation.

## Test plan
- Reset, then push 0..15 on consecutive cycles (DEPTH 16, W 8) -> in_ready low after the 16th push; address 0 reads 16; pop 16 times -> 0..15 in order, out_valid low after the last pop.
- Push 0xA5 into an empty FIFO -> out_valid high and out_data 0xA5 on the next cycle, with no pop issued.
- FIFO full, push and pop in the same cycle -> pop succeeds, push is rejected, fill becomes 15; the next cycle in_ready = 1.
- Hold 8 words, then push and pop together for 40 cycles -> fill stays 8, output sequence continuous across pointer wrap.
- Hold 5 words, drive reset low for a few ns between edges -> out_valid = 0 and in_ready = 1 immediately; after release, address 0 reads 0.
- With FIFO_CHECK_EN defined, pop while empty -> error reported and simulation ends; without the macro -> no effect, fill stays 0.

Source files
------------

// File: rtl/fifo_infill_wrapper_if.sv
// Stream and CSR signals of the free-pointer FIFO, grouped for port connection.
interface fifo_infill_wrapper_if #(
  parameter int DATA_W = 8
);
  logic [2:0]        csr_address;
  logic              csr_read;
  logic              csr_write;
  logic [31:0]       csr_writedata;
  logic [31:0]       csr_readdata;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport slave (
    input  csr_address, csr_read, csr_write, csr_writedata,
    input  in_data, in_valid, out_ready,
    output csr_readdata, in_ready, out_data, out_valid
  );

  modport master (
    output csr_address, csr_read, csr_write, csr_writedata,
    output in_data, in_valid, out_ready,
    input  csr_readdata, in_ready, out_data, out_valid
  );
endinterface

// File: rtl/fifo_infill_wrapper.sv
// Show-ahead single-clock FIFO with fill-level CSR, used as the free-pointer list.
// Define FIFO_CHECK_EN to compile in overflow/underflow simulation checks.
module fifo_infill_wrapper #(
  parameter int SYMBOLS_PER_BEAT = 1,
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int FIFO_DEPTH       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  fifo_infill_wrapper_if.slave   bus
);
  localparam int W  = SYMBOLS_PER_BEAT * BITS_PER_SYMBOL;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FILL_MAX = (AW+1)'(FIFO_DEPTH);

  logic [W-1:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   fill_q, fill_d;
  logic [31:0]   csr_q, csr_d;
  logic          push, pop;
  logic          unused_ok;

  assign bus.in_ready     = (fill_q < FILL_MAX);
  assign bus.out_valid    = (fill_q != '0);
  // Gate the asynchronous RAM read so an empty FIFO presents zero data.
  assign bus.out_data     = bus.out_valid ? mem_q[rd_ptr_q] : '0;
  assign bus.csr_readdata = csr_q;
  assign unused_ok        = ^{bus.csr_write, bus.csr_writedata};

  always_comb begin
    push     = bus.in_valid && bus.in_ready;
    pop      = bus.out_valid && bus.out_ready;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    fill_d   = fill_q + (AW+1)'(push) - (AW+1)'(pop);
    csr_d    = csr_q;
    if (bus.csr_read) begin
      case (bus.csr_address)
        3'd0:    csr_d = 32'(fill_q);
        3'd1:    csr_d = 32'(FIFO_DEPTH);
        default: csr_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      csr_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      csr_q    <= csr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.in_data;
  end

`ifdef FIFO_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset && bus.in_valid && !bus.in_ready)
      $fatal(1, "fifo_infill_wrapper: push while full");
    if (reset && bus.out_ready && !bus.out_valid)
      $fatal(1, "fifo_infill_wrapper: pop while empty");
  end
`else
  // Overflow/underflow attempts are dropped by the push/pop qualifiers above.
`endif
endmodule

// File: tb/tb_fifo_infill_wrapper.sv
// Directed self-checking bench for fifo_infill_wrapper (DEPTH 16, W 8).
module tb_fifo_infill_wrapper;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  fifo_infill_wrapper_if #(.DATA_W(8)) bus ();

  fifo_infill_wrapper #(
    .SYMBOLS_PER_BEAT(1),
    .BITS_PER_SYMBOL (8),
    .FIFO_DEPTH      (16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        iv;
    logic [7:0]  d;
    logic        ordy;
    logic [2:0]  a;
    logic        cw;
    logic        ev;
    logic [7:0]  ed;
    logic        er;
    logic [31:0] ec;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    bus.csr_address   = 3'd0;
    bus.csr_read      = 1'b1;
    bus.csr_write     = 1'b0;
    bus.csr_writedata = '0;
    bus.in_data       = '0;
    bus.in_valid      = 1'b0;
    bus.out_ready     = 1'b0;

    //             iv  d      ordy a     cw    ev    ed     er    ec
    vecs[0] = '{1'b1, 8'hA5, 1'b0, 3'd0, 1'b0, 1'b1, 8'hA5, 1'b1, 32'd0};
    vecs[1] = '{1'b1, 8'h3C, 1'b1, 3'd0, 1'b0, 1'b1, 8'h3C, 1'b1, 32'd1};
    vecs[2] = '{1'b0, 8'h00, 1'b0, 3'd1, 1'b0, 1'b1, 8'h3C, 1'b1, 32'd16};
    vecs[3] = '{1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b1, 8'h3C, 1'b1, 32'd1};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 3'd2, 1'b1, 1'b0, 8'h00, 1'b1, 32'd0};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b0, 8'h00, 1'b1, 32'd0};
    vecs[6] = '{1'b1, 8'h5A, 1'b1, 3'd0, 1'b0, 1'b1, 8'h5A, 1'b1, 32'd0};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 3'd7, 1'b0, 1'b1, 8'h5A, 1'b1, 32'd0};
    vecs[8] = '{1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b0, 8'h00, 1'b1, 32'd1};
    vecs[9] = '{1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b1, 32'd0};

    cyc();
    cyc();
    chk("rst.valid", 32'(bus.out_valid), 32'd0);
    chk("rst.ready", 32'(bus.in_ready), 32'd1);
    chk("rst.data", 32'(bus.out_data), 32'd0);
    chk("rst.csr", bus.csr_readdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    cyc();

    // Table: single-word traffic, show-ahead latency, CSR map, pop while empty.
    for (int i = 0; i < 10; i++) begin
      bus.in_valid      = vecs[i].iv;
      bus.in_data       = vecs[i].d;
      bus.out_ready     = vecs[i].ordy;
      bus.csr_address   = vecs[i].a;
      bus.csr_write     = vecs[i].cw;
      bus.csr_writedata = vecs[i].cw ? 32'hFFFF_FFFF : 32'd0;
      cyc();
      chk($sformatf("vec%0d.valid", i), 32'(bus.out_valid), 32'(vecs[i].ev));
      chk($sformatf("vec%0d.data", i), 32'(bus.out_data), 32'(vecs[i].ed));
      chk($sformatf("vec%0d.ready", i), 32'(bus.in_ready), 32'(vecs[i].er));
      chk($sformatf("vec%0d.csr", i), bus.csr_readdata, vecs[i].ec);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.csr_write = 1'b0;
    bus.csr_address = 3'd0;

    // Fill to full with 0..15.
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(i);
      cyc();
      chk($sformatf("fill%0d.ready", i), 32'(bus.in_ready), (i < 15) ? 32'd1 : 32'd0);
    end
    chk("full.head", 32'(bus.out_data), 32'd0);
    bus.in_valid = 1'b0;
    cyc();
    chk("full.csr", bus.csr_readdata, 32'd16);

    // Push and pop together while full: only the pop lands.
    bus.in_valid = 1'b1; bus.in_data = 8'hFF; bus.out_ready = 1'b1;
    cyc();
    chk("fullpp.ready", 32'(bus.in_ready), 32'd1);
    chk("fullpp.data", 32'(bus.out_data), 32'd1);
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    cyc();
    chk("fullpp.csr", bus.csr_readdata, 32'd15);

    for (int i = 1; i < 16; i++) begin
      chk($sformatf("drain%0d.data", i), 32'(bus.out_data), 32'(i));
      bus.out_ready = 1'b1;
      cyc();
    end
    bus.out_ready = 1'b0;
    chk("drain.valid", 32'(bus.out_valid), 32'd0);
    chk("drain.data", 32'(bus.out_data), 32'd0);

    // Steady-state streaming at fill 8 across pointer wrap.
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(8'h40 + i);
      cyc();
    end
    for (int c = 0; c < 40; c++) begin
      chk($sformatf("stream%0d.data", c), 32'(bus.out_data), 32'(8'(8'h40 + c)));
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'(8'h48 + c);
      bus.out_ready = 1'b1;
      cyc();
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    cyc();
    chk("stream.csr", bus.csr_readdata, 32'd8);
    chk("stream.head", 32'(bus.out_data), 32'h68);

    // Drop to 5 words, then assert reset between edges.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    bus.out_ready = 1'b0;
    cyc();
    chk("pre_rst.csr", bus.csr_readdata, 32'd5);
    #2 reset = 1'b0;
    #1;
    chk("midrst.valid", 32'(bus.out_valid), 32'd0);
    chk("midrst.ready", 32'(bus.in_ready), 32'd1);
    chk("midrst.data", 32'(bus.out_data), 32'd0);
    chk("midrst.csr", bus.csr_readdata, 32'd0);
    #2 reset = 1'b1;
    cyc();
    chk("postrst.csr", bus.csr_readdata, 32'd0);
    chk("postrst.valid", 32'(bus.out_valid), 32'd0);

    // Pop while empty has no effect.
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    cyc();
    chk("uflow.csr", bus.csr_readdata, 32'd0);
    chk("uflow.valid", 32'(bus.out_valid), 32'd0);
    chk("uflow.ready", 32'(bus.in_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
